red_pitaya_pwm_sched: RTL
=========================

RED_PITAYA_PWM_SCHED -- requirements
Module: red_pitaya_pwm_sched

Interface
REQ-001 Parameter CCW, default 24, PWM configuration word width.
REQ-002 Parameter NCH, default 4, number of PWM channels served.
REQ-003 Parameter SLEW, default 24'h000100, max cfg change per commit (used only with RED_PITAYA_PWM_SLEW_EN).
REQ-004 clk  in  1  system clock; one clock domain.
REQ-005 rstn  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid_i  in  2  requester valid; bit0 = system bus, bit1 = DSP.
REQ-007 req_ch_i  in  2x$clog2(NCH)  target channel per requester.
REQ-008 req_data_i  in  2xCCW  requested cfg per requester.
REQ-009 req_ready_o  out  2  grant; transfer when valid && ready.
REQ-010 pwm_s_i  in  NCH  sync pulse from each PWM channel, high one cycle before the channel latches its cfg.
REQ-011 hold_i  in  1  suppress all commits while high.
REQ-012 gang_i  in  1  commit all channels together on pwm_s_i[0].
REQ-013 cfg_o  out  NCHxCCW  registered cfg driven to each PWM channel.
REQ-014 pend_o  out  NCH  shadow value not yet committed.

Function
REQ-015 Arbiter grants at most one requester per cycle; req_ready_o combinational from req_valid_i and round-robin pointer.
REQ-016 Round-robin pointer moves to the other requester after every transfer; single valid requester granted immediately.
REQ-017 Transfer writes req_data to shadow[ch] and sets pend[ch] on the next edge; out-of-range ch is accepted and discarded.
REQ-018 Per-channel FSM: IDLE (pend=0) -> PEND on transfer; PEND -> IDLE on commit; PEND -> PEND on further transfer (last write wins).
REQ-019 Commit trigger: pwm_s_i[ch] when gang_i=0; pwm_s_i[0] for every channel when gang_i=1; no commit while hold_i=1.
REQ-020 Commit: cfg_o[ch] <= shadow[ch] on the trigger edge, so cfg_o is stable the cycle the PWM samples it (latency 1 cycle).
REQ-021 Trigger with pend=0: cfg_o unchanged.
REQ-022 Transfer and commit to same channel in same cycle: commit takes the old shadow, new data stored, pend stays 1.
REQ-023 hold_i released: pending channels commit at their next trigger, never retroactively.
REQ-024 gang_i changes take effect at the next cycle; no commit is duplicated or lost across the change.

Reset
REQ-025 rstn low: cfg_o=0, shadow=0, pend_o=0, pointer=requester 0, all FSMs IDLE; req_ready_o follows REQ-015 with pointer 0.
REQ-026 Reset mid-transfer or mid-commit discards that operation; no partial cfg_o update.

Configuration
REQ-027 Macro RED_PITAYA_PWM_SLEW_EN defined: each commit moves cfg_o[ch] toward shadow[ch] by at most SLEW (unsigned, saturating, no overshoot); pend[ch] clears only when cfg_o equals shadow.
REQ-028 Macro undefined: commit copies shadow in one step; SLEW ignored, no slew logic synthesized.

Structure
REQ-029 Package pwm_sched_pkg holds CCW default, NCH default, requester index constants and the channel FSM state enum.
REQ-030 Sub-module pwm_rr_arb (2-requester round-robin arbiter) instantiated once.

Verification
REQ-031 Req0 writes ch1=24'h123456, pulse pwm_s_i[1] -> cfg_o[1]=24'h123456 next cycle, pend_o[1]=0.
REQ-032 Both valid every cycle for 4 cycles, starting pointer 0 -> grants 0,1,0,1.
REQ-033 gang_i=1, pend ch0..3, pulse pwm_s_i[2] only -> no change; pulse pwm_s_i[0] -> all four cfg_o update same edge.
REQ-034 Write ch0=5 while pwm_s_i[0] high, shadow was 3 -> cfg_o[0]=3, pend_o[0]=1; next pulse -> 5.
REQ-035 hold_i=1 across 3 pulses of pwm_s_i[0] with pending 24'hFF -> cfg_o unchanged; release, next pulse -> 24'hFF.
REQ-036 SLEW_EN, SLEW=24'h100, cfg_o 0 -> shadow 24'h250 -> commits give 24'h100, 24'h200, 24'h250, pend clears on third.

Source files
------------

// File: rtl/pwm_sched_pkg.sv
// rtl/pwm_sched_pkg.sv - shared defaults, requester indices and channel state type for the PWM scheduler
package pwm_sched_pkg;

    localparam int CCW_DEF = 24;
    localparam int NCH_DEF = 4;

    localparam logic REQ_SYS = 1'b0;
    localparam logic REQ_DSP = 1'b1;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_PEND = 1'b1
    } ch_state_t;

endpackage

// File: rtl/pwm_rr_arb.sv
// rtl/pwm_rr_arb.sv - two-requester round-robin arbiter, combinational grant, registered pointer
module pwm_rr_arb
    import pwm_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] valid,
    output logic [1:0] ready
);

    logic ptr;

    // A lone requester wins regardless of the pointer; the pointer only breaks ties.
    always_comb begin
        ready = valid;
        if (valid == 2'b11) begin
            ready      = 2'b00;
            ready[ptr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= REQ_SYS;
        end else if (ready[REQ_SYS]) begin
            ptr <= REQ_DSP;
        end else if (ready[REQ_DSP]) begin
            ptr <= REQ_SYS;
        end
    end

endmodule

// File: rtl/red_pitaya_pwm_sched.sv
// rtl/red_pitaya_pwm_sched.sv - shadowed PWM config scheduler with sync-pulse commit and optional slew limit
// Optional feature: RED_PITAYA_PWM_SLEW_EN limits each commit step to SLEW.
module red_pitaya_pwm_sched
    import pwm_sched_pkg::*;
#(
    parameter int             CCW  = CCW_DEF,
    parameter int             NCH  = NCH_DEF,
    parameter logic [CCW-1:0] SLEW = 24'h000100
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [1:0]                     req_valid_i,
    input  logic [2*((NCH > 1) ? $clog2(NCH) : 1)-1:0] req_ch_i,
    input  logic [2*CCW-1:0]               req_data_i,
    output logic [1:0]                     req_ready_o,
    input  logic [NCH-1:0]                 pwm_s_i,
    input  logic                           hold_i,
    input  logic                           gang_i,
    output logic [NCH*CCW-1:0]             cfg_o,
    output logic [NCH-1:0]                 pend_o
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           xfer;
    logic [CHW-1:0] wr_ch;
    logic [CCW-1:0] wr_data;

    pwm_rr_arb u_arb (
        .clk   (clk),
        .rstn  (rstn),
        .valid (req_valid_i),
        .ready (req_ready_o)
    );

    assign xfer    = |req_ready_o;
    assign wr_ch   = req_ready_o[REQ_DSP] ? req_ch_i[CHW +: CHW]   : req_ch_i[0 +: CHW];
    assign wr_data = req_ready_o[REQ_DSP] ? req_data_i[CCW +: CCW] : req_data_i[0 +: CCW];

`ifdef RED_PITAYA_PWM_SLEW_EN
    function automatic logic [CCW-1:0] slew_step(input logic [CCW-1:0] cur, input logic [CCW-1:0] tgt);
        if (tgt > cur) begin
            return ((tgt - cur) > SLEW) ? cur + SLEW : tgt;
        end
        return ((cur - tgt) > SLEW) ? cur - SLEW : tgt;
    endfunction
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        ch_state_t      state;
        logic [CCW-1:0] shadow;
        logic [CCW-1:0] cfg;
        logic           wr;
        logic           commit;

        // Channel indices at or above NCH never match, so such transfers are simply dropped.
        assign wr     = xfer && (wr_ch == CHW'(c));
        assign commit = !hold_i && (gang_i ? pwm_s_i[0] : pwm_s_i[c]) && (state == CH_PEND);

`ifdef RED_PITAYA_PWM_SLEW_EN
        logic [CCW-1:0] nxt;
        assign nxt = slew_step(cfg, shadow);

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state  <= CH_IDLE;
                shadow <= '0;
                cfg    <= '0;
            end else begin
                if (wr) shadow <= wr_data;
                if (commit) cfg <= nxt;
                if (wr) begin
                    state <= CH_PEND;
                end else if (commit && (nxt == shadow)) begin
                    state <= CH_IDLE;
                end
            end
        end
`else
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state  <= CH_IDLE;
                shadow <= '0;
                cfg    <= '0;
            end else begin
                if (wr) shadow <= wr_data;
                // Commit reads the pre-edge shadow, so a same-cycle write stays pending.
                if (commit) cfg <= shadow;
                if (wr) begin
                    state <= CH_PEND;
                end else if (commit) begin
                    state <= CH_IDLE;
                end
            end
        end
`endif

        assign cfg_o[c*CCW +: CCW] = cfg;
        assign pend_o[c]           = (state == CH_PEND);
    end

endmodule
